// File: rtl/l1_pkg.sv
// Shared types and address-field helpers for the L1 line controller.
// The helpers return 32-bit values so callers pick the width they need.
package l1_pkg;

  typedef enum logic [1:0] {
    ST_INVALID = 2'd0,
    ST_FILL    = 2'd1,
    ST_VALID   = 2'd2,
    ST_WB      = 2'd3
  } l1_line_state_t;

  // Byte address layout: {tag, set, word, 2'b00}
  function automatic logic [31:0] addr_tag(input logic [31:0] a,
                                           input int unsigned set_w,
                                           input int unsigned word_w);
    return a >> (set_w + word_w + 32'd2);
  endfunction

  function automatic logic [31:0] addr_set(input logic [31:0] a,
                                           input int unsigned set_w,
                                           input int unsigned word_w);
    return (a >> (word_w + 32'd2)) & ((32'd1 << set_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_word(input logic [31:0] a,
                                            input int unsigned word_w);
    return (a >> 2) & ((32'd1 << word_w) - 32'd1);
  endfunction

endpackage

// File: rtl/l1_line_store.sv
// WORDS x 32 data store: one byte-masked write port, three async read ports.
// Contents are deliberately not reset; a line is always fully refilled before use.
module l1_line_store #(
  parameter int WORDS  = 8,
  parameter int WORD_W = $clog2(WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [WORD_W-1:0] waddr_i,
  input  logic [3:0]        wbe_i,
  input  logic [31:0]       wdata_i,
  input  logic [WORD_W-1:0] cpu_raddr_i,
  output logic [31:0]       cpu_rdata_o,
  input  logic [WORD_W-1:0] pk_raddr_i,
  output logic [31:0]       pk_rdata_o,
  input  logic [WORD_W-1:0] wb_raddr_i,
  output logic [31:0]       wb_rdata_o
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign cpu_rdata_o = mem_q[cpu_raddr_i];
  assign pk_rdata_o  = mem_q[pk_raddr_i];
  assign wb_rdata_o  = mem_q[wb_raddr_i];

endmodule

// File: rtl/l1_line_ctrl.sv
// One L1 cache line: tag/set/valid/dirty state, CPU and peek lookup, refill and dirty writeback.
// Writeback handshake: a beat transfers on a cycle where wb_valid and wb_ready are both high;
// wb_addr/wb_data hold steady while wb_valid is high and wb_ready is low.
module l1_line_ctrl
  import l1_pkg::*;
#(
  parameter int WORDS = 8,
  parameter int TAG_W = 23,
  parameter int SET_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rreq,
  input  logic             wreq,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wmask,
  output logic             hit,
  output logic [31:0]      rdata,
  input  logic [31:0]      peek_addr,
  output logic             peek_hit,
  output logic [31:0]      peek_rdata,
  input  logic             fill_start,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [SET_W-1:0] fill_set,
  input  logic             fill_wvalid,
  input  logic [31:0]      fill_wdata,
  input  logic             evict_start,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_addr,
  output logic [31:0]      wb_data,
  output logic             done,
  output logic             valid,
  output logic             dirty,
  output logic             busy,
  output logic [TAG_W-1:0] my_tag,
  output logic [SET_W-1:0] my_set,
  output l1_line_state_t   dbg_state
);

  localparam int WORD_W = $clog2(WORDS);
  localparam logic [WORD_W-1:0] CNT_LAST = WORD_W'(WORDS - 1);

  if (TAG_W + SET_W + WORD_W + 2 != 32) begin : g_bad_addr_split
    $error("l1_line_ctrl: TAG_W+SET_W+WORD_W+2 must equal 32");
  end
  if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_words
    $error("l1_line_ctrl: WORDS must be a power of 2 and >= 2");
  end

  l1_line_state_t    state_q;
  logic [WORD_W-1:0] cnt_q;
  logic [TAG_W-1:0]  tag_q;
  logic [SET_W-1:0]  set_q;
  logic              dirty_q;
  logic              done_q;

  logic [31:0] cpu_tag_w, cpu_set_w, cpu_word_w, pk_tag_w, pk_set_w, pk_word_w;
  logic [WORD_W-1:0] cpu_word, pk_word;
  logic cpu_match, pk_match, in_valid, in_wb, wr_hit, last_beat;
  logic unused_bits;

  assign cpu_tag_w  = addr_tag(addr, SET_W, WORD_W);
  assign cpu_set_w  = addr_set(addr, SET_W, WORD_W);
  assign cpu_word_w = addr_word(addr, WORD_W);
  assign pk_tag_w   = addr_tag(peek_addr, SET_W, WORD_W);
  assign pk_set_w   = addr_set(peek_addr, SET_W, WORD_W);
  assign pk_word_w  = addr_word(peek_addr, WORD_W);
  assign cpu_word   = cpu_word_w[WORD_W-1:0];
  assign pk_word    = pk_word_w[WORD_W-1:0];
  assign unused_bits = ^{cpu_word_w[31:WORD_W], pk_word_w[31:WORD_W]};

  assign cpu_match = (cpu_tag_w == 32'(tag_q)) && (cpu_set_w == 32'(set_q));
  assign pk_match  = (pk_tag_w == 32'(tag_q)) && (pk_set_w == 32'(set_q));
  assign in_valid  = (state_q == ST_VALID);
  assign in_wb     = (state_q == ST_WB);
  assign wr_hit    = in_valid && wreq && cpu_match;
  assign last_beat = (cnt_q == CNT_LAST);

  logic [31:0] cpu_rd, pk_rd, wb_rd;
  logic              st_we;
  logic [WORD_W-1:0] st_idx;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;

  // Refill owns the write port in FILL; CPU write hits own it in VALID.
  always_comb begin
    st_we    = 1'b0;
    st_idx   = cpu_word;
    st_be    = wmask;
    st_wdata = wdata;
    if (state_q == ST_FILL) begin
      st_we    = fill_wvalid;
      st_idx   = cnt_q;
      st_be    = 4'hF;
      st_wdata = fill_wdata;
    end else if (wr_hit) begin
      st_we = 1'b1;
    end
  end

  l1_line_store #(.WORDS(WORDS), .WORD_W(WORD_W)) u_store (
    .clk_i       (clk),
    .we_i        (st_we),
    .waddr_i     (st_idx),
    .wbe_i       (st_be),
    .wdata_i     (st_wdata),
    .cpu_raddr_i (cpu_word),
    .cpu_rdata_o (cpu_rd),
    .pk_raddr_i  (pk_word),
    .pk_rdata_o  (pk_rd),
    .wb_raddr_i  (cnt_q),
    .wb_rdata_o  (wb_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INVALID;
      cnt_q   <= '0;
      tag_q   <= '0;
      set_q   <= '0;
      dirty_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_INVALID: begin
          if (fill_start) begin
            tag_q   <= fill_tag;
            set_q   <= fill_set;
            cnt_q   <= '0;
            state_q <= ST_FILL;
          end else if (evict_start) begin
            done_q <= 1'b1;
          end
        end
        ST_FILL: begin
          if (fill_wvalid) begin
            if (last_beat) begin
              cnt_q   <= '0;
              dirty_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_VALID;
            end else begin
              cnt_q <= cnt_q + WORD_W'(1);
            end
          end
        end
        ST_VALID: begin
          if (wr_hit && (wmask != 4'h0)) dirty_q <= 1'b1;
          // A same-edge write hit counts as dirtying the line before the evict decision.
          if (evict_start) begin
            if (dirty_q || (wr_hit && (wmask != 4'h0))) begin
              cnt_q   <= '0;
              state_q <= ST_WB;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_INVALID;
            end
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            if (last_beat) begin
              cnt_q   <= '0;
              dirty_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_INVALID;
            end else begin
              cnt_q <= cnt_q + WORD_W'(1);
            end
          end
        end
        default: state_q <= ST_INVALID;
      endcase
    end
  end

  assign hit        = in_valid && (rreq || wreq) && cpu_match;
  assign rdata      = (in_valid && rreq && cpu_match) ? cpu_rd : 32'h0;
  assign peek_hit   = (in_valid || in_wb) && pk_match;
  assign peek_rdata = peek_hit ? pk_rd : 32'h0;
  assign wb_valid   = in_wb;
  assign wb_addr    = {tag_q, set_q, cnt_q, 2'b00};
  assign wb_data    = wb_rd;
  assign done       = done_q;
  assign valid      = in_valid || in_wb;
  assign dirty      = dirty_q;
  assign busy       = (state_q == ST_FILL) || in_wb;
  assign my_tag     = tag_q;
  assign my_set     = set_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_l1_line_ctrl.sv
// Bench for l1_line_ctrl: directed scenarios plus random traffic, all outputs checked
// every cycle against a line model built from lookup/refill/writeback rules.
module tb_l1_line_ctrl;
  import l1_pkg::*;

  localparam int WORDS = 8;
  localparam int TAG_W = 23;
  localparam int SET_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             rreq, wreq, fill_start, fill_wvalid, evict_start, wb_ready;
  logic [31:0]      addr, wdata, peek_addr, fill_wdata;
  logic [3:0]       wmask;
  logic [TAG_W-1:0] fill_tag;
  logic [SET_W-1:0] fill_set;
  logic             hit, peek_hit, wb_valid, done, valid, dirty, busy;
  logic [31:0]      rdata, peek_rdata, wb_addr, wb_data;
  logic [TAG_W-1:0] my_tag;
  logic [SET_W-1:0] my_set;
  l1_line_state_t   dbg_state;

  l1_line_ctrl #(.WORDS(WORDS), .TAG_W(TAG_W), .SET_W(SET_W)) dut (
    .clk(clk), .reset(reset), .rreq(rreq), .wreq(wreq), .addr(addr), .wdata(wdata),
    .wmask(wmask), .hit(hit), .rdata(rdata), .peek_addr(peek_addr), .peek_hit(peek_hit),
    .peek_rdata(peek_rdata), .fill_start(fill_start), .fill_tag(fill_tag),
    .fill_set(fill_set), .fill_wvalid(fill_wvalid), .fill_wdata(fill_wdata),
    .evict_start(evict_start), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .done(done), .valid(valid), .dirty(dirty),
    .busy(busy), .my_tag(my_tag), .my_set(my_set), .dbg_state(dbg_state)
  );

  // ---------------- line model ----------------
  localparam int M_EMPTY = 0, M_FILLING = 1, M_HELD = 2, M_DRAINING = 3;
  int               m_mode;
  int               m_fill_n;
  logic [TAG_W-1:0] m_tag;
  logic [SET_W-1:0] m_set;
  logic             m_dirty, m_done;
  logic [31:0]      m_mem [WORDS];
  logic [63:0]      exp_q [$];   // pending writeback beats {addr, data}
  int n_vec = 0;
  int n_err = 0;

  function automatic logic line_match(input logic [31:0] a);
    return (a[31:9] == m_tag) && (a[8:5] == m_set);
  endfunction

  function automatic logic [31:0] mk_addr(input logic [TAG_W-1:0] t, input logic [SET_W-1:0] s,
                                          input logic [2:0] w);
    return {t, s, w, 2'b00};
  endfunction

  task automatic m_clear();
    m_mode = M_EMPTY; m_fill_n = 0; m_tag = '0; m_set = '0;
    m_dirty = 1'b0; m_done = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic nd;
    nd = 1'b0;
    case (m_mode)
      M_EMPTY: begin
        if (fill_start) begin
          m_tag = fill_tag; m_set = fill_set; m_fill_n = 0; m_mode = M_FILLING;
        end else if (evict_start) nd = 1'b1;
      end
      M_FILLING: begin
        if (fill_wvalid) begin
          m_mem[m_fill_n] = fill_wdata;
          m_fill_n++;
          if (m_fill_n == WORDS) begin m_mode = M_HELD; m_dirty = 1'b0; nd = 1'b1; end
        end
      end
      M_HELD: begin
        if (wreq && line_match(addr)) begin
          for (int b = 0; b < 4; b++)
            if (wmask[b]) m_mem[addr[4:2]][8*b +: 8] = wdata[8*b +: 8];
          if (wmask != 4'h0) m_dirty = 1'b1;
        end
        if (evict_start) begin
          if (m_dirty) begin
            for (int w = 0; w < WORDS; w++)
              exp_q.push_back({mk_addr(m_tag, m_set, 3'(w)), m_mem[w]});
            m_mode = M_DRAINING;
          end else begin
            m_mode = M_EMPTY; nd = 1'b1;
          end
        end
      end
      default: begin
        if (wb_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin m_mode = M_EMPTY; m_dirty = 1'b0; nd = 1'b1; end
        end
      end
    endcase
    m_done = nd;
  endtask

  always @(posedge clk) begin
    if (!reset) m_clear();
    else model_step();
  end

  always @(negedge reset) m_clear();

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic held, e_hit, e_phit;
    logic [31:0] e_rd, e_prd;
    held   = (m_mode == M_HELD);
    e_hit  = held && (rreq || wreq) && line_match(addr);
    e_rd   = (held && rreq && line_match(addr)) ? m_mem[addr[4:2]] : 32'h0;
    e_phit = (held || m_mode == M_DRAINING) && line_match(peek_addr);
    e_prd  = e_phit ? m_mem[peek_addr[4:2]] : 32'h0;
    check("hit", 64'(hit), 64'(e_hit));
    check("rdata", 64'(rdata), 64'(e_rd));
    check("peek_hit", 64'(peek_hit), 64'(e_phit));
    check("peek_rdata", 64'(peek_rdata), 64'(e_prd));
    check("wb_valid", 64'(wb_valid), 64'(m_mode == M_DRAINING));
    if (m_mode == M_DRAINING && exp_q.size() > 0)
      check("wb_beat", {wb_addr, wb_data}, exp_q[0]);
    check("done", 64'(done), 64'(m_done));
    check("valid", 64'(valid), 64'(held || m_mode == M_DRAINING));
    check("dirty", 64'(dirty), 64'(m_dirty));
    check("busy", 64'(busy), 64'(m_mode == M_FILLING || m_mode == M_DRAINING));
    check("my_tag", 64'(my_tag), 64'(m_tag));
    check("my_set", 64'(my_set), 64'(m_set));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rreq = 0; wreq = 0; addr = 0; wdata = 0; wmask = 0; peek_addr = 0;
    fill_start = 0; fill_tag = 0; fill_set = 0; fill_wvalid = 0; fill_wdata = 0;
    evict_start = 0; wb_ready = 0;
  endtask

  // Streams base+0..base+7; idle cycles before words gap_a/gap_b; poke re-issues fill_start mid-stream.
  task automatic do_fill(input logic [TAG_W-1:0] t, input logic [SET_W-1:0] s,
                         input logic [31:0] base, input int gap_a, input int gap_b, input bit poke);
    fill_tag = t; fill_set = s; fill_start = 1; step(); fill_start = 0;
    for (int w = 0; w < WORDS; w++) begin
      if (w == gap_a || w == gap_b) begin fill_wvalid = 0; step(); end
      fill_wvalid = 1; fill_wdata = base + 32'(w);
      if (poke && w == 4) begin fill_start = 1; fill_tag = t ^ 23'h1; fill_set = s ^ 4'h1; end
      step();
      fill_start = 0;
    end
    fill_wvalid = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] t4_data [WORDS];
  int beats, cyc;

  initial begin
    m_clear();
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1;
    step();

    // Refill with idle gaps, then read word 5.
    do_fill(23'h12345, 4'd3, 32'hA0, 3, 6, 0);
    check("t2_done", 64'(done), 64'h1);
    rreq = 1; addr = mk_addr(23'h12345, 4'd3, 3'd5); #1;
    check("t2_hit", 64'(hit), 64'h1);
    check("t2_rdata", 64'(rdata), 64'hA5);
    step();

    // Byte-masked write over word 2, then read and peek it back.
    rreq = 0; wreq = 1; addr = mk_addr(23'h12345, 4'd3, 3'd2); wmask = 4'b0101; wdata = 32'hFFFFFFFF;
    step();
    wreq = 0; wmask = 0; rreq = 1; peek_addr = addr; #1;
    check("t3_rdata", 64'(rdata), 64'h00FF00FF);
    check("t3_dirty", 64'(dirty), 64'h1);
    check("t3_peek", 64'(peek_rdata), 64'h00FF00FF);
    step();

    // Dirty eviction with wb_ready 1,0,0,1,...
    for (int w = 0; w < WORDS; w++) t4_data[w] = 32'hA0 + 32'(w);
    t4_data[2] = 32'h00FF00FF;
    rreq = 0; evict_start = 1; step(); evict_start = 0;
    beats = 0; cyc = 0;
    while (beats < WORDS && cyc < 100) begin
      wb_ready = (cyc % 3 == 0);
      #1;
      check("t4_wb_valid", 64'(wb_valid), 64'h1);
      check("t4_wb_data", 64'(wb_data), 64'(t4_data[beats]));
      check("t4_wb_word", 64'(wb_addr[4:2]), 64'(beats));
      if (wb_ready) beats++;
      step(); cyc++;
    end
    wb_ready = 0;
    check("t4_beats", 64'(beats), 64'(WORDS));
    check("t4_done", 64'(done), 64'h1);
    check("t4_valid", 64'(valid), 64'h0);
    step();

    // Clean eviction: no writeback, done next cycle.
    do_fill(23'h0ABCD, 4'd9, 32'hB0, -1, -1, 0);
    evict_start = 1; step(); evict_start = 0;
    check("t5_clean_wb", 64'(wb_valid), 64'h0);
    check("t5_clean_done", 64'(done), 64'h1);
    step();

    // Write hit on the same edge as evict: full writeback with the new byte.
    do_fill(23'h0ABCD, 4'd9, 32'hB0, -1, -1, 0);
    wreq = 1; addr = mk_addr(23'h0ABCD, 4'd9, 3'd7); wmask = 4'b1000; wdata = 32'h5A000000;
    evict_start = 1; step();
    wreq = 0; wmask = 0; evict_start = 0;
    check("t5_wb_start", 64'(wb_valid), 64'h1);
    wb_ready = 1; beats = 0; cyc = 0;
    while (!done && cyc < 40) begin
      if (wb_valid) begin
        if (beats == 7) check("t5_wb_new", 64'(wb_data), 64'h5A0000B7);
        beats++;
      end
      step(); cyc++;
    end
    wb_ready = 0;
    check("t5_beats", 64'(beats), 64'(WORDS));
    check("t5_done", 64'(done), 64'h1);
    step();

    // Mismatches by one bit; fill_start during FILL ignored.
    do_fill(23'h00F0F, 4'd6, 32'hC0, 1, -1, 1);
    check("t6_tag_kept", 64'(my_tag), 64'h00F0F);
    check("t6_set_kept", 64'(my_set), 64'h6);
    rreq = 1; addr = mk_addr(23'h00F0E, 4'd6, 3'd1); #1;
    check("t6_tag_miss_hit", 64'(hit), 64'h0);
    check("t6_tag_miss_rd", 64'(rdata), 64'h0);
    addr = mk_addr(23'h00F0F, 4'd7, 3'd1); #1;
    check("t6_set_miss_hit", 64'(hit), 64'h0);
    rreq = 0; wreq = 1; wmask = 4'hF; wdata = 32'hDEADBEEF; step();
    wreq = 0; rreq = 1; addr = mk_addr(23'h00F0F, 4'd6, 3'd1); #1;
    check("t6_mem_kept", 64'(rdata), 64'hC1);
    check("t6_dirty_kept", 64'(dirty), 64'h0);
    step();

    // Reset in the middle of a writeback.
    rreq = 0; wreq = 1; addr = mk_addr(23'h00F0F, 4'd6, 3'd0); wmask = 4'h1; wdata = 32'h11;
    step();
    wreq = 0; wmask = 0; evict_start = 1; step(); evict_start = 0;
    wb_ready = 1; step(); step();
    reset = 0; rreq = 1; addr = mk_addr(23'h00F0F, 4'd6, 3'd0); #1;
    check("t1_valid", 64'(valid), 64'h0);
    check("t1_dirty", 64'(dirty), 64'h0);
    check("t1_busy", 64'(busy), 64'h0);
    check("t1_wb_valid", 64'(wb_valid), 64'h0);
    check("t1_hit", 64'(hit), 64'h0);
    step();
    addr = 32'h0; #1;
    check("t1_hit_zero_addr", 64'(hit), 64'h0);
    reset = 1; idle_inputs();
    step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [TAG_W-1:0] t;
      logic [SET_W-1:0] s;
      reset       = ($urandom_range(0, 399) != 0);
      fill_start  = ($urandom_range(0, 19) == 0);
      fill_tag    = ($urandom_range(0, 1) != 0) ? 23'h12345 : 23'h12344;
      fill_set    = ($urandom_range(0, 1) != 0) ? 4'd3 : 4'd2;
      fill_wvalid = ($urandom_range(0, 9) < 6);
      fill_wdata  = $urandom;
      evict_start = ($urandom_range(0, 24) == 0);
      wb_ready    = ($urandom_range(0, 1) != 0);
      rreq        = ($urandom_range(0, 1) != 0);
      wreq        = ($urandom_range(0, 2) == 0);
      wmask       = 4'($urandom_range(0, 15));
      wdata       = $urandom;
      t = m_tag; s = m_set;
      case ($urandom_range(0, 5))
        0: t = t ^ (23'h1 << $urandom_range(0, TAG_W - 1));
        1: s = s ^ (4'h1 << $urandom_range(0, SET_W - 1));
        default: ;
      endcase
      addr      = mk_addr(t, s, 3'($urandom_range(0, 7)));
      peek_addr = ($urandom_range(0, 3) == 0) ? $urandom : mk_addr(m_tag, m_set, 3'($urandom_range(0, 7)));
      step();
    end
    reset = 1; idle_inputs();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
